// File: rtl/rx_dram_writer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | rx_dram_writer: drains 128-word RX packets, packs 4x16b lanes per 64b     |
// | DRAM write, checks 0xDEAD/0xBEEF framing. Rev 1.0                         |
// +--------------------------------------------------------------------------+
module rx_dram_writer #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 25,
  parameter int BASE_ADDR    = 0,
  parameter int REGION_WORDS = 1048576,
  parameter int PKT_WORDS    = 128
) (
  input  logic                  DRAM_RD_clk,
  input  logic                  rst_n,
  input  logic                  Enable,
  input  logic                  Buffer_Data_Ready,
  input  logic                  RX_Buffer_empty,
  input  logic [15:0]           Buffer_RD_Data,
  output logic                  DRAM_RD_req,
  output logic                  DRAM_WR_req,
  output logic [ADDR_WIDTH-1:0] DRAM_WR_addr,
  output logic [DATA_WIDTH-1:0] DRAM_WR_data,
  input  logic                  DRAM_WR_waitrequest,
  output logic [31:0]           Pkt_Count,
  output logic [15:0]           Pkt_Err_Count,
  output logic                  Wrapped,
  output logic                  Busy
);

  localparam int                    c_wcnt_w    = $clog2(PKT_WORDS + 1);
  localparam logic [ADDR_WIDTH-1:0] c_base_addr = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(BASE_ADDR + REGION_WORDS - 1);
  localparam logic [c_wcnt_w-1:0]   c_pkt_words = c_wcnt_w'(PKT_WORDS);
  localparam logic [c_wcnt_w-1:0]   c_last_word = c_wcnt_w'(PKT_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [c_wcnt_w-1:0]   r_word_cnt;
  logic [1:0]            r_lane;
  logic [DATA_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wrapped;
  logic                  r_busy;
  logic                  r_err_flag;
  logic [31:0]           r_pkt_cnt;
  logic [15:0]           r_err_cnt;
  logic                  w_rd_req;
  logic                  w_wr_req;
  logic                  w_accept;
  logic                  w_frame_bad;

  always_ff @(posedge DRAM_RD_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // A pop is only ever issued from READ with data present, so the upstream
  // buffer can never underflow even when it empties mid-packet.
  always_comb begin
    w_next   = r_state;
    w_rd_req = 1'b0;
    w_wr_req = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Enable && Buffer_Data_Ready && !RX_Buffer_empty) w_next = S_READ;
      end
      S_READ: begin
        if (!RX_Buffer_empty) begin
          w_rd_req = 1'b1;
          w_next   = S_CAPTURE;
        end
      end
      S_CAPTURE: w_next = (r_lane == 2'd3) ? S_WRITE : S_READ;
      S_WRITE: begin
        w_wr_req = 1'b1;
        if (!DRAM_WR_waitrequest) w_next = (r_word_cnt == c_pkt_words) ? S_DONE : S_READ;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept    = (r_state == S_WRITE) && !DRAM_WR_waitrequest;
  assign w_frame_bad = ((r_word_cnt == '0)          && (Buffer_RD_Data != 16'hDEAD)) ||
                       ((r_word_cnt == c_last_word) && (Buffer_RD_Data != 16'hBEEF));

  always_ff @(posedge DRAM_RD_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
      r_lane     <= 2'd0;
      r_data     <= '0;
      r_addr     <= c_base_addr;
      r_wrapped  <= 1'b0;
      r_busy     <= 1'b0;
      r_err_flag <= 1'b0;
      r_pkt_cnt  <= 32'd0;
      r_err_cnt  <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_next == S_READ) begin
            r_busy     <= 1'b1;
            r_err_flag <= 1'b0;
            r_word_cnt <= '0;
            r_lane     <= 2'd0;
          end
        end
        S_CAPTURE: begin
          r_data[{r_lane, 4'b0000} +: 16] <= Buffer_RD_Data;
          r_word_cnt <= r_word_cnt + 1'b1;
          r_lane     <= r_lane + 1'b1;
          if (w_frame_bad) r_err_flag <= 1'b1;
        end
        S_WRITE: begin
          if (w_accept) begin
            if (r_addr == c_last_addr) begin
              r_addr    <= c_base_addr;
              r_wrapped <= 1'b1;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_pkt_cnt <= r_pkt_cnt + 32'd1;
          if (r_err_flag && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign DRAM_RD_req   = w_rd_req;
  assign DRAM_WR_req   = w_wr_req;
  assign DRAM_WR_addr  = r_addr;
  assign DRAM_WR_data  = r_data;
  assign Pkt_Count     = r_pkt_cnt;
  assign Pkt_Err_Count = r_err_cnt;
  assign Wrapped       = r_wrapped;
  assign Busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rx_dram_writer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rx_dram_writer: directed bench for rx_dram_writer (default region and  |
// | a small 64-word region at 0x100 driven side by side). Rev 1.0             |
// +--------------------------------------------------------------------------+
module tb_rx_dram_writer;
  localparam int AW = 25;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Enable;
  logic        Buffer_Data_Ready;
  logic        hold_empty;
  logic        wr_wait;
  logic [15:0] rd_data;
  logic        RX_Buffer_empty;
  int          fifo_cnt;

  logic          d_rd_req, d_wr_req, d_wrapped, d_busy;
  logic [AW-1:0] d_addr;
  logic [63:0]   d_data;
  logic [31:0]   d_pkt;
  logic [15:0]   d_err;
  logic          w_rd_req, w_wr_req, w_wrapped, w_busy;
  logic [AW-1:0] w_addr;
  logic [63:0]   w_data;
  logic [31:0]   w_pkt;
  logic [15:0]   w_err;

  always #5 clk = ~clk;
  assign RX_Buffer_empty = hold_empty || (fifo_cnt == 0);

  rx_dram_writer u_dut (
    .DRAM_RD_clk(clk), .rst_n(rst_n), .Enable(Enable),
    .Buffer_Data_Ready(Buffer_Data_Ready), .RX_Buffer_empty(RX_Buffer_empty),
    .Buffer_RD_Data(rd_data), .DRAM_RD_req(d_rd_req), .DRAM_WR_req(d_wr_req),
    .DRAM_WR_addr(d_addr), .DRAM_WR_data(d_data), .DRAM_WR_waitrequest(wr_wait),
    .Pkt_Count(d_pkt), .Pkt_Err_Count(d_err), .Wrapped(d_wrapped), .Busy(d_busy)
  );

  rx_dram_writer #(.BASE_ADDR(32'h100), .REGION_WORDS(64)) u_dut_wrap (
    .DRAM_RD_clk(clk), .rst_n(rst_n), .Enable(Enable),
    .Buffer_Data_Ready(Buffer_Data_Ready), .RX_Buffer_empty(RX_Buffer_empty),
    .Buffer_RD_Data(rd_data), .DRAM_RD_req(w_rd_req), .DRAM_WR_req(w_wr_req),
    .DRAM_WR_addr(w_addr), .DRAM_WR_data(w_data), .DRAM_WR_waitrequest(wr_wait),
    .Pkt_Count(w_pkt), .Pkt_Err_Count(w_err), .Wrapped(w_wrapped), .Busy(w_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [15:0]   fifo_q[$];
  logic [63:0]   exp_q[$];
  int            pop_cnt;
  int            n_writes;
  int            wait_n;
  int            stall_cnt;
  logic [AW-1:0] exp_addr_def, exp_addr_wrap;
  logic [AW-1:0] first_addr_def, first_addr_wrap;
  logic [63:0]   first_data, last_data;

  // Upstream buffer: a pop seen in one cycle delivers data right after that edge.
  initial begin : fifo_model
    logic seen;
    forever begin
      @(negedge clk);
      seen = d_rd_req;
      @(posedge clk);
      #1;
      if (seen) begin
        chk("pop_when_nonempty", 64'(fifo_q.size() != 0), 64'd1);
        if (fifo_q.size() != 0) rd_data = fifo_q.pop_front();
        pop_cnt++;
        fifo_cnt = fifo_q.size();
      end
    end
  end

  initial begin : waitreq_gen
    wr_wait   = 1'b0;
    stall_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (d_wr_req) begin
        if (stall_cnt < wait_n) begin
          wr_wait = 1'b1;
          stall_cnt++;
        end else begin
          wr_wait = 1'b0;
        end
      end else begin
        wr_wait   = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  initial begin : write_monitor
    logic        prev_stall;
    logic [AW-1:0] held_addr;
    logic [63:0] held_data;
    logic [63:0] exp;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_addr_stable", 64'(d_addr), 64'(held_addr));
          chk("stall_data_stable", d_data, held_data);
        end
        if (d_wr_req) chk("no_rdreq_in_write", 64'(d_rd_req), 64'd0);
        if (d_wr_req && !wr_wait) begin
          exp = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hxxxx_xxxx_xxxx_xxxx;
          chk("write_data", d_data, exp);
          chk("wrap_write_data", w_data, exp);
          chk("write_addr", 64'(d_addr), 64'(exp_addr_def));
          chk("wrap_write_addr", 64'(w_addr), 64'(exp_addr_wrap));
          if (n_writes == 0) begin
            first_addr_def  = d_addr;
            first_addr_wrap = w_addr;
            first_data      = d_data;
          end
          last_data = d_data;
          n_writes++;
          exp_addr_def  = exp_addr_def + 1'b1;
          exp_addr_wrap = (exp_addr_wrap == AW'('h13F)) ? AW'('h100) : exp_addr_wrap + 1'b1;
        end
        prev_stall = d_wr_req && wr_wait;
        held_addr  = d_addr;
        held_data  = d_data;
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1, "watchdog");
  end

  task automatic push_pkt(input logic [15:0] first, input logic [15:0] last, input bit with_exp);
    logic [15:0] w[128];
    for (int k = 0; k < 128; k++) begin
      w[k] = (k == 0) ? first : (k == 1) ? 16'h1234 : (k == 127) ? last : 16'(k - 1);
      fifo_q.push_back(w[k]);
    end
    if (with_exp)
      for (int i = 0; i < 32; i++) exp_q.push_back({w[4*i+3], w[4*i+2], w[4*i+1], w[4*i]});
    fifo_cnt = fifo_q.size();
  endtask

  task automatic wait_busy(input logic lvl, input int max, input string name);
    int n = 0;
    while (d_busy !== lvl && n < max) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(name, 64'(d_busy), 64'(lvl));
  endtask

  task automatic wait_pops(input int target, input string name);
    int n = 0;
    while (pop_cnt < target && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(name, 64'(pop_cnt), 64'(target));
  endtask

  task automatic start_pkt(input logic [15:0] first, input logic [15:0] last);
    pop_cnt  = 0;
    n_writes = 0;
    push_pkt(first, last, 1'b1);
    Buffer_Data_Ready = 1'b1;
    wait_busy(1'b1, 20, "busy_start");
    Buffer_Data_Ready = 1'b0;
  endtask

  task automatic finish_pkt();
    wait_busy(1'b0, 3000, "busy_end");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("writes_per_pkt", 64'(n_writes), 64'd32);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_rd_req", 64'(d_rd_req), 64'd0);
    chk("rst_wr_req", 64'(d_wr_req), 64'd0);
    chk("rst_addr", 64'(d_addr), 64'd0);
    chk("rst_wrap_addr", 64'(w_addr), 64'h100);
    chk("rst_data", d_data, 64'd0);
    chk("rst_pkt", 64'(d_pkt), 64'd0);
    chk("rst_err", 64'(d_err), 64'd0);
    chk("rst_wrapped", 64'(w_wrapped), 64'd0);
    chk("rst_busy", 64'(d_busy), 64'd0);
  endtask

  typedef struct {
    logic [15:0]   first;
    logic [15:0]   last;
    int            wt;
    logic [31:0]   pkt;
    logic [15:0]   err;
    logic          wrapped;
    logic [AW-1:0] a_def;
    logic [AW-1:0] a_wrap;
  } vec_t;

  vec_t vec[4];

  initial begin : main
    int bad;
    vec[0] = '{16'hDEAD, 16'hBEEF, 0, 32'd1, 16'd0, 1'b0, AW'(0),  AW'('h100)};
    vec[1] = '{16'hDEAD, 16'hBEEF, 5, 32'd2, 16'd0, 1'b1, AW'(32), AW'('h120)};
    vec[2] = '{16'hDEAD, 16'hBEEE, 0, 32'd3, 16'd1, 1'b1, AW'(64), AW'('h100)};
    vec[3] = '{16'hDEAE, 16'hBEEF, 1, 32'd4, 16'd2, 1'b1, AW'(96), AW'('h120)};

    rst_n = 1'b0; Enable = 1'b0; Buffer_Data_Ready = 1'b0; hold_empty = 1'b0;
    rd_data = 16'd0; fifo_cnt = 0; wait_n = 0; pop_cnt = 0; n_writes = 0;
    exp_addr_def = '0; exp_addr_wrap = AW'('h100);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #2;
    rst_n  = 1'b1;
    Enable = 1'b1;

    for (int i = 0; i < 4; i++) begin
      wait_n = vec[i].wt;
      start_pkt(vec[i].first, vec[i].last);
      finish_pkt();
      chk("pkt_count", 64'(d_pkt), 64'(vec[i].pkt));
      chk("err_count", 64'(d_err), 64'(vec[i].err));
      chk("wrap_sticky", 64'(w_wrapped), 64'(vec[i].wrapped));
      chk("no_wrap_default", 64'(d_wrapped), 64'd0);
      chk("pkt_first_addr", 64'(first_addr_def), 64'(vec[i].a_def));
      chk("pkt_first_addr_wrap", 64'(first_addr_wrap), 64'(vec[i].a_wrap));
      if (i == 0) begin
        chk("first_write_data", first_data, 64'h0002_0001_1234_DEAD);
        chk("last_write_data", last_data, 64'hBEEF_007D_007C_007B);
      end
    end

    // Buffer runs dry after word 50 for 20 cycles
    wait_n = 0;
    start_pkt(16'hDEAD, 16'hBEEF);
    wait_pops(51, "pops_before_hold");
    hold_empty = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (d_rd_req) bad++;
    end
    chk("rdreq_while_empty", 64'(bad), 64'd0);
    chk("pops_during_hold", 64'(pop_cnt), 64'd51);
    @(posedge clk); #2;
    hold_empty = 1'b0;
    wait_pops(52, "resume_pop");
    chk("resume_word51", 64'(rd_data), 64'h0032);
    finish_pkt();
    chk("stall_pkt_count", 64'(d_pkt), 64'd5);
    chk("stall_err_count", 64'(d_err), 64'd2);

    // Enable dropped at word 10 with another packet waiting
    start_pkt(16'hDEAD, 16'hBEEF);
    wait_pops(10, "pops_before_disable");
    Enable = 1'b0;
    Buffer_Data_Ready = 1'b1;
    push_pkt(16'hDEAD, 16'hBEEF, 1'b0);
    finish_pkt();
    chk("disable_pkt_count", 64'(d_pkt), 64'd6);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (d_busy || d_rd_req) bad++;
    end
    chk("idle_while_disabled", 64'(bad), 64'd0);
    Buffer_Data_Ready = 1'b0;
    fifo_q.delete();
    fifo_cnt = 0;
    Enable = 1'b1;

    // Reset pulse at word 70
    start_pkt(16'hDEAD, 16'hBEEF);
    wait_pops(70, "pops_before_reset");
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    fifo_q.delete();
    fifo_cnt = 0;
    exp_q.delete();
    exp_addr_def  = '0;
    exp_addr_wrap = AW'('h100);
    @(posedge clk); #2;
    rst_n = 1'b1;

    start_pkt(16'hDEAD, 16'hBEEF);
    finish_pkt();
    chk("post_reset_pkt", 64'(d_pkt), 64'd1);
    chk("post_reset_err", 64'(d_err), 64'd0);
    chk("post_reset_addr", 64'(first_addr_def), 64'd0);
    chk("post_reset_addr_wrap", 64'(first_addr_wrap), 64'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_dram_writer.md
Name: rx_dram_writer

Overview:
Downstream consumer of the RX double buffer, running in the DRAM_RD_clk domain. Drains one complete front-end packet at a time: 128 x 16-bit words (0xDEAD, timestamp, 125 payload words, 0xBEEF). Packs every 4 words into one 64-bit DRAM write, issues it on a simple write port with waitrequest, and advances a wrapping address. Checks framing and keeps packet and error counters for status readback.

Parameters:
DATA_WIDTH, 64, DRAM write word width; fixed to 4 x 16-bit lanes.
ADDR_WIDTH, 25, DRAM word-address width.
BASE_ADDR, 0, first DRAM word address of the capture region.
REGION_WORDS, 1048576, capture region size in DRAM words; must be a multiple of 32.
PKT_WORDS, 128, 16-bit words per packet.

Ports:
DRAM_RD_clk  in  1  sole clock
rst_n  in  1  reset, asynchronous, active-low
Enable  in  1  capture enable; sampled only at packet boundaries
Buffer_Data_Ready  in  1  a complete packet is readable from the RX buffer
RX_Buffer_empty  in  1  selected RX buffer is empty
Buffer_RD_Data  in  16  RX buffer read data; valid 1 cycle after DRAM_RD_req
DRAM_RD_req  out  1  RX buffer pop request
DRAM_WR_req  out  1  DRAM write request
DRAM_WR_addr  out  ADDR_WIDTH  DRAM word address
DRAM_WR_data  out  64  DRAM write data
DRAM_WR_waitrequest  in  1  DRAM not accepting; a write completes on a cycle with req=1 and waitrequest=0
Pkt_Count  out  32  packets fully written to DRAM
Pkt_Err_Count  out  16  packets with a framing error; saturates at 0xFFFF
Wrapped  out  1  sticky; the address has wrapped at least once
Busy  out  1  high from packet start until its last write is accepted

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0, except DRAM_WR_addr=BASE_ADDR.
  - State IDLE; word counter 0; lane counter 0.
- States:
  - IDLE -> READ when Enable=1, Buffer_Data_Ready=1 and RX_Buffer_empty=0 (sampled in IDLE only). Busy is set on this transition.
  - READ: assert DRAM_RD_req for one cycle when RX_Buffer_empty=0; otherwise stall with rdreq=0. Next cycle goes to CAPTURE.
  - CAPTURE: latch Buffer_RD_Data into lane[lane counter]. Lane 0 is DRAM_WR_data[15:0]; lane 3 is [63:48]. Increment the word and lane counters.
    - Lane counter reached 4 (wraps to 0) -> WRITE.
    - Otherwise -> READ.
  - WRITE: DRAM_WR_req=1; data and address held stable until waitrequest=0. On accept:
    - Address increments; BASE_ADDR+REGION_WORDS-1 wraps to BASE_ADDR and sets Wrapped.
    - Word counter=PKT_WORDS -> DONE; otherwise -> READ.
  - DONE (1 cycle):
    - Pkt_Count+1 (32-bit natural wrap).
    - Framing error -> Pkt_Err_Count+1, saturating at 0xFFFF.
    - Clear Busy -> IDLE.
- Framing check:
  - Word 0 must equal 0xDEAD; word 127 must equal 0xBEEF.
  - Any mismatch sets a per-packet error flag, cleared on leaving IDLE.
  - An errored packet is still written in full; the address advances normally (fixed 32 DRAM words per packet).
- DRAM_RD_req is never asserted outside READ, and never while RX_Buffer_empty=1: no underflow pops.
- Maximum one rdreq per 2 cycles. One packet takes at least 128x2 + 32 cycles plus wait states.
- RX_Buffer_empty rising mid-packet stalls READ indefinitely; the partial state is kept and there is no timeout.
- Enable dropping mid-packet: the current packet completes, then the block stays in IDLE.
- Buffer_Data_Ready is ignored outside IDLE.
- Reset asserted mid-operation: immediate return to the reset state, and any in-flight DRAM request is dropped. The upstream FIFO contents are not this block's responsibility.

Test Plan:
1. Reset, Enable=1, feed one clean packet (0xDEAD, 0x1234, payload 0x0001..0x007D, 0xBEEF), waitrequest=0 -> 32 writes at addr 0..31. First data 0x0002_0001_1234_DEAD; last data 0xBEEF_007D_007C_007B. Pkt_Count=1, Pkt_Err_Count=0, Busy low afterwards.
2. Same packet with waitrequest held high 5 cycles on every write -> data and address stable during the stall; no DRAM_RD_req while in WRITE; identical final DRAM image.
3. Packet with word 127 = 0xBEEE -> all 32 writes issued; Pkt_Err_Count=1, Pkt_Count=1.
4. REGION_WORDS=64, BASE_ADDR=0x100, three packets -> addresses 0x100..0x13F, then 0x100..0x11F; Wrapped=1 after the 64th write.
5. Force RX_Buffer_empty=1 for 20 cycles after word 50 -> DRAM_RD_req stays 0 for the whole window; resumes at word 51; packet is correct.
6. Drop Enable at word 10; separately, pulse rst_n low at word 70 -> first: packet completes and no new packet starts while Buffer_Data_Ready=1. Second: all outputs return to reset values within the same cycle, DRAM_WR_addr=BASE_ADDR.
